// File: rtl/led_band_pkg.sv
// Shared constants and state encoding for the LED band column fetch path.
package led_band_pkg;

    localparam int N_LEDS        = 48;
    localparam int N_CHANNELS    = 3;
    localparam int N_COLUMNS     = 96;
    localparam int BYTES_PER_COL = N_LEDS * N_CHANNELS;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/led_band_skid_fifo.sv
// Two-entry {last, data} FIFO that absorbs the memory read latency and
// downstream stalls between the fetch FSM and the serializer stream.
module led_band_skid_fifo #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_q;
    logic             rd_q;
    logic [1:0]       cnt_q;
    logic             do_pop;

    assign empty     = (cnt_q == 2'd0);
    assign occupancy = cnt_q;
    assign do_pop    = pop && !empty;
    // Head reads as zero when empty so the stream outputs idle at a known value.
    assign head      = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) begin
                wr_q <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && cnt_q == 2'd2));

endmodule

// File: rtl/led_band_column_fetch.sv
// Walks one cylinder column of the LED band memory and streams its bytes,
// with a credit scheme so the 2-entry FIFO can never overflow.
module led_band_column_fetch #(
    parameter int R_ADDR_WIDTH = 15,
    parameter int R_DATA_WIDTH = 8,
    parameter int N_LEDS       = led_band_pkg::N_LEDS,
    parameter int N_CHANNELS   = led_band_pkg::N_CHANNELS,
    parameter int N_COLUMNS    = led_band_pkg::N_COLUMNS,
    parameter int COL_WIDTH    = $clog2(N_COLUMNS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    col_valid,
    output logic                    col_ready,
    input  logic [COL_WIDTH-1:0]    col_idx,
    output logic                    col_err,
    output logic                    read,
    output logic [R_ADDR_WIDTH-1:0] r_addr,
    input  logic [R_DATA_WIDTH-1:0] r_data,
    output logic [R_DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy
);

    import led_band_pkg::fetch_state_t;
    import led_band_pkg::IDLE;
    import led_band_pkg::FETCH;
    import led_band_pkg::DRAIN;

    localparam int BYTES = N_LEDS * N_CHANNELS;
    localparam int K_W   = $clog2(BYTES + 1);
    localparam logic [K_W-1:0]       K_LAST    = K_W'(BYTES - 1);
    localparam logic [COL_WIDTH:0]   N_COL_LIM = (COL_WIDTH + 1)'(N_COLUMNS);

    fetch_state_t            state_q;
    logic [R_ADDR_WIDTH-1:0] base_q;
    logic [R_ADDR_WIDTH-1:0] base_d;
    logic [K_W-1:0]          k_q;
    logic                    inflight_q;
    logic                    inflight_last_q;
    logic                    col_err_q;

    logic [1:0]              occ;
    logic                    fifo_empty;
    logic                    pop;
    logic                    credit;
    logic                    issue;
    logic                    col_in_range;
    logic [R_DATA_WIDTH:0]   fifo_head;

    assign col_in_range = ({1'b0, col_idx} < N_COL_LIM);
    assign base_d       = R_ADDR_WIDTH'(col_idx) * R_ADDR_WIDTH'(BYTES);

    // A read is allowed only if, counting the byte still in flight and the
    // byte leaving this cycle, the FIFO will have room when its data lands.
    assign pop    = out_valid && out_ready;
    assign credit = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign issue  = (state_q == FETCH) && credit && !rst;

    assign read      = issue;
    assign r_addr    = base_q + R_ADDR_WIDTH'(k_q);
    assign col_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign col_err   = col_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            base_q          <= '0;
            k_q             <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            col_err_q       <= 1'b0;
        end else begin
            col_err_q       <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue && (k_q == K_LAST);
            case (state_q)
                IDLE: begin
                    if (col_valid) begin
                        if (col_in_range) begin
                            base_q  <= base_d;
                            k_q     <= '0;
                            state_q <= FETCH;
                        end else begin
                            col_err_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        k_q <= k_q + K_W'(1);
                        if (k_q == K_LAST) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Empty FIFO with nothing in flight means the last byte was taken.
                    if (fifo_empty && !inflight_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    led_band_skid_fifo #(
        .WIDTH (R_DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, r_data}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .occupancy (occ)
    );

    assign out_valid = !fifo_empty;
    assign out_last  = fifo_head[R_DATA_WIDTH];
    assign out_data  = fifo_head[R_DATA_WIDTH-1:0];

endmodule
